// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built around a single full_addr cell
// and a registered carry. An addition takes one bit per clock, LSB first.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   start      request, sampled only in IDLE
//   a, b       operands, captured on the accepting edge
//   c_in       carry-in, captured on the accepting edge
//   busy       high while the addition is in progress (ADD)
//   done       one-cycle pulse, sum/carry_out freshly updated
//   sum        registered WIDTH-bit result
//   carry_out  registered final carry

// One-bit full adder cell.
module full_addr (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic carry_out
);
  assign sum       = a ^ b ^ c_in;
  assign carry_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;

  logic fa_sum, fa_co;

  // The single adder cell always looks at the current LSBs and carry.
  full_addr u_fa (
    .a        (a_sh_q[0]),
    .b        (b_sh_q[0]),
    .c_in     (carry_q),
    .sum      (fa_sum),
    .carry_out(fa_co)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ADD;
      ADD:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ADD:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    co_d    = co_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = c_in;
          cnt_d   = '0;
        end
      end
      ADD: begin
        // Result bits enter at the MSB so after WIDTH shifts bit 0 lands at acc[0].
        acc_d   = {fa_sum, acc_q[WIDTH-1:1]};
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + 1'b1;
        // Publish on the last bit, using the acc value that includes it.
        if (cnt_q == LAST) begin
          sum_d = acc_d;
          co_d  = fa_co;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
    end
  end

  assign sum       = sum_q;
  assign carry_out = co_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       start8, cin8, busy8, done8, co8;
  logic [7:0] a8, b8, sum8;
  // 4-bit instance
  logic       start4, cin4, busy4, done4, co4;
  logic [3:0] a4, b4, sum4;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .c_in(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .c_in(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .carry_out(co4)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  // One full 8-bit transaction. ign_cyc>0 pulses a stray start (AA+55) on that
  // busy cycle. Checks latency, busy length, result hold, result and done width.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      input logic [7:0] es, input logic eco, input int ign_cyc,
                      input string tag);
    logic [8:0] prev;
    int busy_n, lat;
    bit seen, held;
    prev = {co8, sum8};
    @(negedge clk);
    a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    busy_n = 0; lat = 0; seen = 0; held = 1;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (done8) begin
        seen = 1; lat = i;
      end else begin
        if (busy8) busy_n++;
        if ({co8, sum8} !== prev) held = 0;
      end
      if (i == ign_cyc) begin
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
      end else begin
        start8 = 1'b0;
      end
    end
    start8 = 1'b0;
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, lat, 9);
    check({tag, " busy_cycles"}, busy_n, 8);
    check({tag, " result_held"}, 32'(held), 32'd1);
    check({tag, " sum"}, sum8, es);
    check({tag, " carry_out"}, co8, eco);
    @(negedge clk);
    check({tag, " done_one_cycle"}, {busy8, done8}, 2'b00);
  endtask

  vec_t vecs[6];

  initial begin
    int idx, cyc, last_done, quiet;
    logic [4:0] exp4;
    logic [8:0] exp8;
    logic [7:0] ra, rb;
    logic rc;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

    rst_n = 1'b0;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start4 = 0; a4 = 0; b4 = 0; cin4 = 0;
    repeat (3) @(negedge clk);
    check("reset8 outputs", {busy8, done8, co8, sum8}, 11'd0);
    check("reset4 outputs", {busy4, done4, co4, sum4}, 7'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    foreach (vecs[i])
      run8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co, 0,
           $sformatf("vec%0d", i));

    // Stray start during busy is ignored; previous result (vec5: 00/1) held
    run8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 3, "ignored_start");

    // Random vectors against arithmetic model
    for (int k = 0; k < 40; k++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      exp8 = 9'(ra) + 9'(rb) + 9'(rc);
      run8(ra, rb, rc, exp8[7:0], exp8[8], 0, $sformatf("rand%0d", k));
    end

    // Make sum nonzero, then reset asynchronously mid-operation
    run8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 0, "pre_reset");
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h44; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(negedge clk);
    check("busy before reset", 32'(busy8), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset outputs", {busy8, done8, co8, sum8}, 11'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8 || busy8) quiet = 0;
    end
    check("no done after reset", 32'(quiet), 32'd1);
    run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 0, "post_reset");

    // WIDTH=4 exhaustive with start held high
    @(negedge clk);
    a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0; start4 = 1'b1;
    idx = 0; cyc = 0; last_done = -1;
    while (idx < 512 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (done4) begin
        exp4 = 5'(idx[3:0]) + 5'(idx[7:4]) + 5'(idx[8]);
        check($sformatf("w4 sum idx%0d", idx), {co4, sum4}, exp4);
        if (last_done >= 0)
          check($sformatf("w4 spacing idx%0d", idx), cyc - last_done, 6);
        last_done = cyc;
        idx++;
        // Next accepting edge is two edges away (DONE->IDLE, then IDLE accept).
        a4 = idx[3:0]; b4 = idx[7:4]; cin4 = idx[8];
      end
    end
    start4 = 1'b0;
    check("w4 all results", idx, 512);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder built around one `full_addr` cell (ports `a`, `b`, `c_in`, `sum`, `carry_out`) and a registered carry.
- Accepts two operands plus carry-in on a start strobe and processes one bit per clock, LSB first.
- Returns the registered WIDTH-bit sum and final carry with a one-cycle done pulse.
- Serves as the sequencing stage that feeds the full-adder cell and consumes its outputs; it is the area-minimal alternative to a ripple chain.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
- clk  input  1  single system clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- c_in  input  1  carry-in; captured on accepted start.
- busy  output  1  high while an addition is in progress (ADD state).
- done  output  1  one-cycle pulse; sum/carry_out valid and updated.
- sum  output  WIDTH  registered result.
- carry_out  output  1  registered final carry.

Behaviour:
- Interface timing: one clock; reset is asynchronous and active-low (`clk`, `rst_n`).
- Reset (`rst_n`=0, any time, including mid-operation):
  - state=IDLE; busy=0, done=0, sum=0, carry_out=0.
  - Internal shift registers, carry_q and bit counter cleared.
  - An in-flight addition is discarded; no done follows.
- Internal state:
  - a_sh, b_sh (WIDTH each): operand shift registers.
  - acc (WIDTH): partial-sum shift register.
  - carry_q (1): registered carry.
  - cnt: clog2(WIDTH) bits.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - On start=1 at edge E0: a_sh<=a, b_sh<=b, carry_q<=c_in, cnt<=0, go to ADD.
  - On start=0: stay in IDLE.
- ADD (busy=1), at each edge:
  - The `full_addr` cell sees a_sh[0], b_sh[0] and carry_q.
  - acc<={cell.sum, acc[WIDTH-1:1]}; a_sh and b_sh shift right, zero-fill; carry_q<=cell.carry_out; cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge: also load sum<=final acc value (including this bit), carry_out<=final carry, and go to DONE.
- DONE:
  - done=1, busy=0, for exactly one cycle; then unconditionally return to IDLE.
  - start is ignored in DONE; the earliest new acceptance is the cycle after done.
- Latency:
  - Start accepted at E0 → done high in the cycle after edge E0+WIDTH.
  - Issue interval is WIDTH+2 cycles minimum.
- start while busy or in DONE: ignored; operands are not re-captured and the in-flight result is unaffected.
- Input stability: a, b and c_in are don't-care except at the accepting edge.
- sum/carry_out:
  - Change only at the ADD→DONE edge (or reset).
  - Hold the last result indefinitely through IDLE and subsequent ADD.
- Arithmetic: {carry_out,sum} == a + b + c_in, modulo 2^(WIDTH+1); no truncation.
- Back-to-back: holding start high continuously produces one addition per WIDTH+2 cycles, each capturing the operands present at its accepting edge.

Test Plan:
- WIDTH=8, reset then start with a=8'h05, b=8'h03, c_in=0:
  - busy high 8 cycles; done pulses once, 8 cycles after the start edge.
  - sum=8'h08, carry_out=0.
- a=8'hFF, b=8'h01, c_in=0 → sum=8'h00, carry_out=1.
- a=8'hFF, b=8'hFF, c_in=1 → sum=8'hFF, carry_out=1.
- Start with a=8'h10, b=8'h20; pulse start again with a=8'hAA, b=8'h55 on cycle 3 of busy:
  - Second start is ignored.
  - Single done; sum=8'h30, carry_out=0.
  - Previous sum held unchanged until that done.
- Assert rst_n=0 asynchronously (between clock edges) at cycle 4 of an addition:
  - busy, done, sum and carry_out go to 0 immediately.
  - No done after release.
  - A fresh start a=8'h7F, b=8'h01 completes with sum=8'h80, carry_out=0.
- WIDTH=4, exhaustive over all a, b, c_in (512 cases, start held high):
  - {carry_out,sum} matches a+b+c_in on every done.
  - done spacing is exactly 6 cycles.
